// File: rtl/cacheline_adaptor_pkg.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor_pkg: sizing constants and shared types for the adaptor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cacheline_adaptor_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_WIDTH   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;

endpackage

`default_nettype wire

// File: rtl/cacheline_adaptor_if.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor_if: cache-side and memory-side buses of the adaptor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  line_t line_i;
  line_t line_o;
  addr_t address_i;
  logic  read_i;
  logic  write_i;
  logic  resp_o;
  beat_t burst_i;
  beat_t burst_o;
  addr_t address_o;
  logic  read_o;
  logic  write_o;
  logic  resp_i;

  // Adaptor view: signal directions match the _i/_o suffixes.
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  // Environment view: the cache and main memory together.
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

`default_nettype wire

// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor: one cacheline read/write <-> BEATS-beat memory burst
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cacheline_adaptor (
  input  logic                clk,
  input  logic                rst_n,
  cacheline_adaptor_if.slave  bus
);
  import cacheline_adaptor_pkg::*;

  state_e state_q, state_d;
  cnt_t   cnt_q,   cnt_d;
  line_t  line_q,  line_d;
  addr_t  addr_q,  addr_d;
  logic   last_beat;

  assign last_beat     = (cnt_q == CNT_WIDTH'(BEATS - 1));
  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // Strobes decode straight from state so reset drops them without a clock.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    addr_d      = addr_q;
    bus.read_o  = 1'b0;
    bus.write_o = 1'b0;
    bus.resp_o  = 1'b0;
    bus.burst_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.read_i) begin
          addr_d  = bus.address_i;
          cnt_d   = '0;
          state_d = ST_READ;
        end else if (bus.write_i) begin
          addr_d  = bus.address_i;
          line_d  = bus.line_i;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end

      ST_READ: begin
        bus.read_o = 1'b1;
        if (bus.resp_i) begin
          line_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = bus.burst_i;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_WRITE: begin
        bus.write_o = 1'b1;
        bus.burst_o = line_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];
        if (bus.resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        bus.resp_o = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor: directed stimulus with a queue-based response checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  typedef struct {
    line_t line;
    addr_t addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  beat_t beat_q[$];
  exp_t  m_e;
  beat_t m_b;
  int    total     = 0;
  int    bad       = 0;
  int    resp_seen = 0;
  int    resp_want = 0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the adaptor presents a line or a beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_o) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got resp_o=1 expected no response pending");
        end else begin
          m_e = exp_q.pop_front();
          chk("line_o", bus.line_o, m_e.line);
          chk("address_o_resp", bus.address_o, m_e.addr);
        end
      end
      if (bus.write_o && bus.resp_i) begin
        if (beat_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got burst_o=%0h expected no beat pending", bus.burst_o);
        end else begin
          m_b = beat_q.pop_front();
          chk("burst_o", bus.burst_o, m_b);
        end
      end
      if (bus.resp_o || bus.read_o || bus.write_o)
        chk("strobe_exclusive", $countones({bus.resp_o, bus.read_o, bus.write_o}), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_txn(input line_t line);
    chk("resp_o_done", bus.resp_o, 1'b1);
    chk("busy_in_done", {bus.read_o, bus.write_o}, 2'b00);
    resp_want++;
    step();
    chk("resp_o_single", bus.resp_o, 1'b0);
    chk("no_reissue", {bus.read_o, bus.write_o}, 2'b00);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    step();
    chk("idle_quiet", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    chk("line_o_hold", bus.line_o, line);
  endtask

  task automatic do_read(input addr_t addr, input beat_t [3:0] bts, input logic [15:0] pat,
                         input int n, input logic with_write);
    exp_t e;
    int   k  = 0;
    int   rd = 0;
    int   wr = 0;
    e.line = bts;
    e.addr = addr;
    exp_q.push_back(e);
    bus.read_i    = 1'b1;
    bus.write_i   = with_write;
    bus.address_i = addr;
    bus.line_i    = {8{32'hBAD0_F00D}};
    step();
    bus.address_i = ~addr;
    chk("address_o_burst", bus.address_o, addr);
    for (int i = 0; i < n; i++) begin
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? bts[k] : {$urandom, $urandom};
      if (pat[i]) k++;
      if (bus.read_o)  rd++;
      if (bus.write_o) wr++;
      step();
    end
    bus.resp_i = 1'b0;
    chk("read_o_cycles", rd, n);
    chk("write_o_quiet", wr, 0);
    finish_txn(e.line);
  endtask

  task automatic do_write(input addr_t addr, input line_t line, input logic [15:0] pat,
                          input int n, input logic abort);
    exp_t e;
    int   wr = 0;
    e.line = line;
    e.addr = addr;
    exp_q.push_back(e);
    for (int j = 0; j < BEATS; j++) beat_q.push_back(line[j*BURST_WIDTH +: BURST_WIDTH]);
    bus.write_i   = 1'b1;
    bus.address_i = addr;
    bus.line_i    = line;
    step();
    bus.line_i    = ~line;
    bus.address_i = ~addr;
    for (int i = 0; i < n; i++) begin
      bus.resp_i  = pat[i];
      bus.burst_i = {$urandom, $urandom};
      if (bus.write_o) wr++;
      step();
    end
    bus.resp_i = 1'b0;
    if (abort) begin
      chk("write_o_pre_rst", bus.write_o, 1'b1);
      chk("beats_left", beat_q.size(), BEATS - n);
      void'(exp_q.pop_back());
      beat_q.delete();
      #2 rst_n = 1'b0;
      #1;
      chk("write_o_async_rst", bus.write_o, 1'b0);
      chk("resp_o_in_rst", bus.resp_o, 1'b0);
      bus.write_i = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      chk("idle_after_rst", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
      chk("line_cleared", bus.line_o, '0);
      chk("addr_cleared", bus.address_o, '0);
    end else begin
      chk("write_o_cycles", wr, n);
      finish_txn(line);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    rst_n         = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_strobes", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    chk("rst_line_o", bus.line_o, '0);
    chk("rst_address_o", bus.address_o, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Contiguous read, memory answers one cycle after seeing read_o.
    do_read(32'h0000_1240,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            16'b1_1110, 5, 1'b0);

    // Write with one gap between beats.
    do_write(32'h0000_2000,
             {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0},
             16'b11_1010, 6, 1'b0);

    // Gapped read: resp_i pattern 1,0,0,1,1,0,1.
    do_read(32'hABCD_0060,
            {64'h3C3C_3C3C_3C3C_3C3C, 64'hC3C3_C3C3_C3C3_C3C3,
             64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5},
            16'b101_1001, 7, 1'b0);

    // read_i and write_i together: read wins, write_o must stay low.
    do_read(32'h0000_0010,
            {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
             64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000},
            16'b1_1110, 5, 1'b1);

    // Reset after the second beat of a write.
    do_write(32'h0000_3000, {4{64'h5555_AAAA_5555_AAAA}}, 16'b11, 2, 1'b1);

    // Read after the aborted write restarts from beat 0.
    do_read(32'h0000_4000,
            {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
            16'b1111, 4, 1'b0);

    step();
    chk("sb_drain", exp_q.size(), 0);
    chk("beat_drain", beat_q.size(), 0);
    chk("resp_count", resp_seen, resp_want);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
